uart_byte_rx: RTL and testbench
===============================

# uart_byte_rx

Asynchronous serial receiver for the PC-to-board link: oversamples the `rx_in` line, recovers 8N1 frames at one of four baud rates chosen by the `choose` switches, and presents each byte with a one-cycle strobe. It sits directly upstream of the receive-control/display path, which latches `rx_data` on `rx_stop` and uses `rx_en` as a busy indication.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency in Hz; all bit divisors derive from it.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `rx_in` input 1: serial line, idle high, LSB first.
- `choose` input 2: baud select; 00=9600, 01=19200, 10=38400, 11=115200.
- `rx_data` output 8: last correctly received byte; held until the next good frame.
- `rx_stop` output 1: one-cycle pulse; `rx_data` is valid in the same cycle.
- `rx_en` output 1: high from the validated start bit until the end of the stop bit.
- `frame_err` output 1: one-cycle pulse on a bad stop bit, or on a parity error when parity is compiled in.

## Operation
- `rx_in` passes through a 2-FF synchronizer before any use. The synchronized value is the "line" below.
- Divisor DIV = CLK_HZ / baud, using integer division. At 50 MHz: 5208, 2604, 1302, 434.
- `choose` is captured into a frame register when the falling edge is detected. Changing `choose` mid-frame has no effect until the next frame.
- States: IDLE, START, DATA, (PARITY), STOP, WAIT_HI.
- IDLE: wait for a line falling edge (previous 1, current 0). On the edge, load the bit counter with 0 and go to START.
- START: count to DIV/2 − 1, then sample the line.
  - If the line is 0, the start bit is valid: assert `rx_en`, clear the counter, go to DATA.
  - If the line is 1, treat it as a glitch: return to IDLE with no outputs.
- DATA: every DIV cycles, sample the line into shift-register bit `idx`, LSB first. `idx` runs 0..7; after bit 7, go to STOP (or PARITY).
- STOP: sample after DIV cycles.
  - If the line is 1: load `rx_data` from the shift register, pulse `rx_stop`, deassert `rx_en`, go to IDLE.
  - If the line is 0: pulse `frame_err`, deassert `rx_en`, leave `rx_data` unchanged, go to WAIT_HI.
- WAIT_HI: stay until the line reads 1, then go to IDLE. This prevents a break condition from being decoded as back-to-back frames.
- `rx_stop` and `frame_err` are never asserted in the same cycle.

## Timing
- Reset values: `rx_data`=8'h00, `rx_stop`=0, `rx_en`=0, `frame_err`=0, state IDLE, synchronizer flops=1.
- Reset asserted mid-frame aborts the frame immediately. No strobe is produced, and the current `rx_data` is lost (it is reset to 0).
- Edge-to-start-sample latency is 2 synchronizer cycles plus DIV/2 cycles. Each following sample is exactly DIV cycles after the previous one, so samples land mid-bit.
- `rx_stop` rises 10·DIV − DIV/2 + 3 cycles (±1) after the `rx_in` falling edge. For DIV=434 that is 4126 cycles ±1.
- `rx_en` deasserts in the same cycle that `rx_stop`/`frame_err` pulses.
- Back-to-back frames are supported: a falling edge in the cycle after a good STOP is accepted (IDLE is entered that cycle).
- Counter width is 13 bits, enough for DIV up to 8191.

## Configuration
- Macro: `UART_RX_PARITY_EN`.
- Defined: the frame is 8E1. The PARITY state samples a ninth bit DIV cycles after bit 7 and compares it with the XOR of the data bits.
  - A mismatch sets an internal flag. At STOP, `frame_err` pulses instead of `rx_stop` and `rx_data` is not updated.
  - `rx_stop` latency grows by DIV.
- Undefined: 8N1, with no PARITY state and no parity logic.

## Test plan
- `choose`=11, send 8'hA5 with a good stop bit -> `rx_data`=8'hA5, `rx_stop` high for 1 cycle about 4126 cycles after the start edge, `frame_err` stays 0.
- `choose`=00, send 8'h3C then 8'hFF back-to-back -> two `rx_stop` pulses about 52080 cycles apart, `rx_data` ends at 8'hFF.
- 100-cycle low glitch on idle line, `choose`=11 -> no `rx_en`, no `rx_stop`; state returns to IDLE.
- Send 8'h55 with stop bit 0, then hold the line low for 3 bit times -> exactly one `frame_err` pulse, `rx_data` keeps its previous value, no further frames until the line goes high.
- Drive `rst`=0 while bit 4 of 8'h81 is being received, then release and send 8'h12 -> no strobe for the aborted frame, `rx_data`=8'h00 after reset, then 8'h12 with one `rx_stop`.
- With `UART_RX_PARITY_EN`: send 8'h07 with parity bit 0 (wrong) -> `frame_err` pulse, no `rx_stop`. Send 8'h07 with parity bit 1 -> `rx_stop`, `rx_data`=8'h07.

Source files
------------

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: oversampling UART receiver, 8N1 at four selectable baud rates.
// Define UART_RX_PARITY_EN to receive 8E1 frames with a checked even-parity bit.
module uart_byte_rx #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  input  logic [1:0] choose,
  output logic [7:0] rx_data,
  output logic       rx_stop,
  output logic       rx_en,
  output logic       frame_err
);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HI} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;
`endif
  localparam logic [12:0] DIV0 = 13'(CLK_HZ / 9600);
  localparam logic [12:0] DIV1 = 13'(CLK_HZ / 19200);
  localparam logic [12:0] DIV2 = 13'(CLK_HZ / 38400);
  localparam logic [12:0] DIV3 = 13'(CLK_HZ / 115200);
  state_t      state, next;
  logic        s1, line, line_d, fall, tick, good, bad, par_bad;
  logic [12:0] cnt, div, lim;
  logic [2:0]  idx;
  logic [7:0]  shreg;
  logic [1:0]  choose_r;
  assign fall = line_d & ~line;
  assign div  = choose_r == 2'd0 ? DIV0 : choose_r == 2'd1 ? DIV1 : choose_r == 2'd2 ? DIV2 : DIV3;
  assign lim  = state == START ? (div >> 1) - 13'd1 : div - 13'd1;
  assign tick = cnt == lim;
  always_ff @(posedge clk or negedge rst)
    if (!rst) {s1, line, line_d} <= 3'b111;
    else      {s1, line, line_d} <= {rx_in, s1, line};
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    if (fall) next = START;
      START:   if (tick) next = line ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
      DATA:    if (tick && idx == 3'd7) next = PARITY;
      PARITY:  if (tick) next = STOP;
`else
      DATA:    if (tick && idx == 3'd7) next = STOP;
`endif
      STOP:    if (tick) next = line ? IDLE : WAIT_HI;
      WAIT_HI: if (line) next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    good = state == STOP && tick && line && !par_bad;
    bad  = state == STOP && tick && (!line || par_bad);
  end
`ifdef UART_RX_PARITY_EN
  logic par_err;
  assign par_bad = par_err;
  assign rx_en   = state == DATA || state == PARITY || state == STOP;
  // Even parity: the received ninth bit must equal the XOR of the data bits.
  always_ff @(posedge clk or negedge rst)
    if (!rst) par_err <= 1'b0;
    else      par_err <= state == START ? 1'b0 : state == PARITY && tick ? line != ^shreg : par_err;
`else
  assign par_bad = 1'b0;
  assign rx_en   = state == DATA || state == STOP;
`endif
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      choose_r  <= '0;
      rx_data   <= '0;
      rx_stop   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt       <= state == IDLE || state == WAIT_HI || tick ? '0 : cnt + 13'd1;
      idx       <= state != DATA ? 3'd0 : tick ? idx + 3'd1 : idx;
      shreg     <= state == DATA && tick ? {line, shreg[7:1]} : shreg;
      choose_r  <= state == IDLE && fall ? choose : choose_r;
      rx_data   <= good ? shreg : rx_data;
      rx_stop   <= good;
      frame_err <= bad;
    end
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: scoreboard bench for uart_byte_rx at a reduced clock so every baud rate stays short.
module tb_uart_byte_rx;
  localparam int CLK_HZ = 2_304_000;
  localparam int BAUD [4] = '{9600, 19200, 38400, 115200};
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  logic       clk = 1'b0, rst = 1'b0, rx_in = 1'b1;
  logic [1:0] choose = 2'b11;
  logic [7:0] rx_data;
  logic       rx_stop, rx_en, frame_err;
  typedef struct {logic [7:0] d; int t0; int lat;} exp_t;
  exp_t q[$];
  exp_t e_m;
  int   checks = 0, errors = 0, cyc = 0, stop_cnt = 0, fe_cnt = 0;
  int   prev_stop_t = 0, last_stop_t = 0, lat_m, s, f, dv;
  logic en_prev = 1'b0, en_seen;

  uart_byte_rx #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .choose(choose),
    .rx_data(rx_data), .rx_stop(rx_stop), .rx_en(rx_en), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int div_of(input logic [1:0] c);
    return CLK_HZ / BAUD[c];
  endfunction

  task automatic bitx(input logic v, input int n);
    rx_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic watch(input int n);
    repeat (n) begin
      @(negedge clk);
      en_seen |= rx_en;
    end
  endtask

  // Good frames are scored on rx_stop; chg flips choose after the start bit to prove it is latched per frame.
  task automatic send(input logic [7:0] d, input logic stop_v, input logic par_flip, input logic chg);
    int n;
    n = div_of(choose);
    if (stop_v && !par_flip) q.push_back('{d, cyc, NB * n - n / 2 + 3});
    bitx(1'b0, n);
    if (chg) choose = ~choose;
    for (int i = 0; i < 8; i++) begin
      bitx(d[i], n);
      if (i == 1) chk("busy", rx_en, 1'b1);
    end
`ifdef UART_RX_PARITY_EN
    bitx(^d ^ par_flip, n);
`endif
    bitx(stop_v, n);
    if (chg) choose = ~choose;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 16 && q.size() != 0; i++) @(negedge clk);
    chk(tag, q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (rx_stop) begin
        stop_cnt++;
        prev_stop_t = last_stop_t;
        last_stop_t = cyc;
        chk("excl", frame_err, 1'b0);
        chk("en_drop", rx_en, 1'b0);
        chk("en_prev", en_prev, 1'b1);
        if (q.size() == 0) chk("unexpected_stop", 1, 0);
        else begin
          e_m = q.pop_front();
          lat_m = cyc - e_m.t0;
          chk("data", rx_data, e_m.d);
          chk("lat_ok", lat_m >= e_m.lat - 1 && lat_m <= e_m.lat + 1, 1'b1);
        end
      end
      if (frame_err) fe_cnt++;
      en_prev = rx_en;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_stop", rx_stop, 1'b0);
    chk("rst_en", rx_en, 1'b0);
    chk("rst_fe", frame_err, 1'b0);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    choose = 2'b11;
    send(8'hA5, 1'b1, 1'b0, 1'b0);
    drain("a5_drain");
    chk("a5_data", rx_data, 8'hA5);
    chk("a5_fe", fe_cnt, 0);
    choose = 2'b00;
    send(8'h3C, 1'b1, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0, 1'b0);
    drain("b2b_drain");
    chk("b2b_gap", last_stop_t - prev_stop_t, NB * div_of(2'b00));
    chk("b2b_data", rx_data, 8'hFF);
    choose = 2'b01;
    send(8'h5A, 1'b1, 1'b0, 1'b0);
    choose = 2'b10;
    send(8'hC3, 1'b1, 1'b0, 1'b1);
    drain("rates_drain");
    chk("rates_data", rx_data, 8'hC3);
    s = stop_cnt;
    f = fe_cnt;
    en_seen = 1'b0;
    choose = 2'b00;
    rx_in = 1'b0;
    watch(100);
    rx_in = 1'b1;
    watch(div_of(2'b00));
    choose = 2'b11;
    rx_in = 1'b0;
    watch(div_of(2'b11) / 4);
    rx_in = 1'b1;
    watch(div_of(2'b11));
    chk("glitch_en", en_seen, 1'b0);
    chk("glitch_stop", stop_cnt, s);
    chk("glitch_fe", fe_cnt, f);
    send(8'h66, 1'b1, 1'b0, 1'b0);
    drain("post_glitch_drain");
    chk("post_glitch_data", rx_data, 8'h66);
    s = stop_cnt;
    f = fe_cnt;
    dv = div_of(2'b11);
    send(8'h55, 1'b0, 1'b0, 1'b0);
    en_seen = 1'b0;
    watch(3 * dv);
    rx_in = 1'b1;
    watch(dv);
    chk("ferr_count", fe_cnt, f + 1);
    chk("ferr_stop", stop_cnt, s);
    chk("ferr_data", rx_data, 8'h66);
    chk("ferr_break_en", en_seen, 1'b0);
    send(8'h99, 1'b1, 1'b0, 1'b0);
    drain("post_ferr_drain");
    chk("post_ferr_data", rx_data, 8'h99);
    s = stop_cnt;
    bitx(1'b0, dv);
    for (int i = 0; i < 4; i++) bitx(i == 0 || i == 7, dv);
    bitx(1'b0, dv / 2);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_data", rx_data, 8'h00);
    chk("abort_en", rx_en, 1'b0);
    chk("abort_stop", rx_stop, 1'b0);
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2 * dv) @(negedge clk);
    chk("post_rst_data", rx_data, 8'h00);
    chk("abort_no_stop", stop_cnt, s);
    send(8'h12, 1'b1, 1'b0, 1'b0);
    drain("post_rst_drain");
    chk("post_rst_rx", rx_data, 8'h12);
    chk("post_rst_count", stop_cnt, s + 1);
`ifdef UART_RX_PARITY_EN
    s = stop_cnt;
    f = fe_cnt;
    send(8'h07, 1'b1, 1'b1, 1'b0);
    chk("par_bad_fe", fe_cnt, f + 1);
    chk("par_bad_stop", stop_cnt, s);
    chk("par_bad_data", rx_data, 8'h12);
    send(8'h07, 1'b1, 1'b0, 1'b0);
    drain("par_good_drain");
    chk("par_good_data", rx_data, 8'h07);
`endif
    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
